// File: rtl/sprite_rom_arbiter_if.sv
// Sprite ROM arbiter bus: requester handshake, ROM port and read-data return.
// The arbiter connects through the slave modport; requesters and the ROM model
// connect through the master modport.
interface sprite_rom_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 15,
  parameter int DATA_W  = 5
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        lock;
  logic [NUM_REQ*ADDR_W-1:0] addr_in;
  logic [NUM_REQ-1:0]        gnt;
  logic [ADDR_W-1:0]         rom_addr;
  logic [DATA_W-1:0]         rom_data;
  logic [DATA_W-1:0]         rdata;
  logic [NUM_REQ-1:0]        rdata_valid;

  modport slave (
    input  req, lock, addr_in, rom_data,
    output gnt, rom_addr, rdata, rdata_valid
  );

  modport master (
    output req, lock, addr_in, rom_data,
    input  gnt, rom_addr, rdata, rdata_valid
  );
endinterface

// File: rtl/sprite_rom_arbiter.sv
// Sprite ROM arbiter: shares one synchronous single-port sprite ROM among
// NUM_REQ requesters. One access per cycle in aggregate, fixed 2-cycle latency
// from gnt to rdata_valid. A winner raising lock keeps the ROM to itself until
// it drops req or lock.
// Build option: define SPRITE_ARB_FIXED_PRIO_EN to replace round-robin with
// lowest-index-wins arbitration in the ARB state.
module sprite_rom_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 15,
  parameter int DATA_W  = 5
) (
  input logic                 Clk,
  input logic                 Reset,
  sprite_rom_arbiter_if.slave bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef logic [IDX_W-1:0] idx_t;
  typedef enum logic [0:0] {ARB, LOCKED} state_t;

  state_t             state, state_nxt;
  idx_t               owner, owner_nxt;

  logic [NUM_REQ-1:0] gnt_q;
  logic [NUM_REQ-1:0] gnt_d1;
  logic [ADDR_W-1:0]  rom_addr_q;
  logic [DATA_W-1:0]  rdata_q;
  logic [NUM_REQ-1:0] rdata_valid_q;

  logic [NUM_REQ-1:0] eligible;
  logic [ADDR_W-1:0]  addr_arr [NUM_REQ];

  // Result of arbitration across all eligible requesters
  logic               any_win;
  idx_t               any_idx;

  // Final winner after FSM qualification
  logic               win_valid;
  idx_t               win_idx;
  logic [NUM_REQ-1:0] win_onehot;

`ifndef SPRITE_ARB_FIXED_PRIO_EN
  idx_t               ptr;
`endif

  // A requester granted this cycle sits out the next arbitration
  assign eligible = bus.req & ~gnt_q;

  assign bus.gnt         = gnt_q;
  assign bus.rom_addr    = rom_addr_q;
  assign bus.rdata       = rdata_q;
  assign bus.rdata_valid = rdata_valid_q;

  // Unpack the flattened request address bus
  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      addr_arr[i] = bus.addr_in[i*ADDR_W +: ADDR_W];
    end
  end

`ifdef SPRITE_ARB_FIXED_PRIO_EN
  // Fixed priority: lowest eligible index wins
  always_comb begin
    any_win = 1'b0;
    any_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!any_win && eligible[idx_t'(i)]) begin
        any_win = 1'b1;
        any_idx = idx_t'(i);
      end
    end
  end
`else
  // Round-robin: search begins one past the last winner and wraps
  always_comb begin
    int unsigned cand;
    idx_t        cidx;
    any_win = 1'b0;
    any_idx = '0;
    cand    = 0;
    cidx    = '0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      cand = int'(ptr) + off;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      cidx = idx_t'(cand);
      if (!any_win && eligible[cidx]) begin
        any_win = 1'b1;
        any_idx = cidx;
      end
    end
  end
`endif

  // Next-state and winner selection; a released lock rejoins full
  // arbitration in the same cycle it is released
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    win_valid = 1'b0;
    win_idx   = '0;
    case (state)
      ARB: begin
        win_valid = any_win;
        win_idx   = any_idx;
      end
      LOCKED: begin
        if (!bus.req[owner] || !bus.lock[owner]) begin
          state_nxt = ARB;
          win_valid = any_win;
          win_idx   = any_idx;
        end else begin
          win_valid = eligible[owner];
          win_idx   = owner;
        end
      end
      default: begin
        state_nxt = ARB;
      end
    endcase
    if (win_valid && bus.lock[win_idx]) begin
      state_nxt = LOCKED;
      owner_nxt = win_idx;
    end
  end

  // One-hot form of the winner for the grant register
  always_comb begin
    win_onehot = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      win_onehot[i] = win_valid && (win_idx == idx_t'(i));
    end
  end

  // FSM state and lock owner registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= ARB;
      owner <= '0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
    end
  end

  // Grant pulse and ROM address; address only moves on a grant
  always_ff @(posedge Clk) begin
    if (Reset) begin
      gnt_q      <= '0;
      rom_addr_q <= '0;
    end else begin
      gnt_q <= win_onehot;
      if (win_valid) begin
        rom_addr_q <= addr_arr[win_idx];
      end
    end
  end

`ifndef SPRITE_ARB_FIXED_PRIO_EN
  // Round-robin pointer tracks the most recent winner
  always_ff @(posedge Clk) begin
    if (Reset) begin
      ptr <= idx_t'(NUM_REQ - 1);
    end else if (win_valid) begin
      ptr <= win_idx;
    end
  end
`endif

  // Read return pipeline: grant tag follows the ROM's one-cycle read delay;
  // reset clears the in-flight tag so no stale read is ever reported
  always_ff @(posedge Clk) begin
    if (Reset) begin
      gnt_d1        <= '0;
      rdata_valid_q <= '0;
      rdata_q       <= '0;
    end else begin
      gnt_d1        <= gnt_q;
      rdata_valid_q <= gnt_d1;
      if (|gnt_d1) begin
        rdata_q <= bus.rom_data;
      end
    end
  end

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench for sprite_rom_arbiter with a read-return scoreboard.
// Expected grants are hand-derived per step; each expected grant queues the
// read tag and ROM contents due two edges later.
`timescale 1ns/1ps
module tb_sprite_rom_arbiter;
  localparam int NUM_REQ = 3;
  localparam int ADDR_W  = 15;
  localparam int DATA_W  = 5;

  typedef struct {
    int unsigned        due;
    logic [NUM_REQ-1:0] tag;
    logic [DATA_W-1:0]  data;
  } exp_t;

`ifdef SPRITE_ARB_FIXED_PRIO_EN
  localparam logic [2:0] S2_EXP [6] = '{3'b001, 3'b010, 3'b001, 3'b010, 3'b001, 3'b010};
`else
  localparam logic [2:0] S2_EXP [6] = '{3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001};
`endif

  logic              clk = 1'b0;
  logic              reset;
  int unsigned       cyc = 0;
  int                checks = 0;
  int                failures = 0;
  bit                mon_en = 1'b0;
  exp_t              sbq [$];
  logic [ADDR_W-1:0] a [NUM_REQ];
  logic [ADDR_W-1:0] exp_addr;

  sprite_rom_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  sprite_rom_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .Clk   (clk),
    .Reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DATA_W-1:0] rom_fn(input logic [ADDR_W-1:0] ad);
    return ad[4:0] ^ ad[9:5] ^ ad[14:10] ^ 5'h15;
  endfunction

  // Synchronous ROM model
  always @(posedge clk) bus.rom_data <= rom_fn(bus.rom_addr);

  function automatic int oh2idx(input logic [2:0] g);
    if (g[0]) return 0;
    if (g[1]) return 1;
    return 2;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of requests, then check grant and ROM address after the edge
  task automatic step(input logic [2:0] r, input logic [2:0] l, input logic [2:0] g,
                      input string tag, input bit rnd);
    if (rnd) begin
      for (int i = 0; i < NUM_REQ; i++) a[i] = ADDR_W'($urandom);
    end
    bus.req  = r;
    bus.lock = l;
    for (int i = 0; i < NUM_REQ; i++) bus.addr_in[i*ADDR_W +: ADDR_W] = a[i];
    @(posedge clk);
    #1;
    if (g != 3'b000) begin
      exp_addr = a[oh2idx(g)];
      sbq.push_back('{due: cyc + 2, tag: g, data: rom_fn(a[oh2idx(g)])});
    end
    chk({tag, ".gnt"}, 32'(bus.gnt), 32'(g));
    chk({tag, ".rom_addr"}, 32'(bus.rom_addr), 32'(exp_addr));
  endtask

  // Read-return monitor: every cycle either a queued read is due or nothing is
  always @(negedge clk) begin
    if (mon_en) begin
      if (sbq.size() > 0 && sbq[0].due == cyc) begin
        chk("rdata_valid", 32'(bus.rdata_valid), 32'(sbq[0].tag));
        chk("rdata", 32'(bus.rdata), 32'(sbq[0].data));
        void'(sbq.pop_front());
      end else begin
        chk("rdata_valid_idle", 32'(bus.rdata_valid), 32'(0));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b1;
    bus.req     = '0;
    bus.lock    = '0;
    bus.addr_in = '0;
    for (int i = 0; i < NUM_REQ; i++) a[i] = '0;
    exp_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.gnt", 32'(bus.gnt), 32'(0));
    chk("reset.rom_addr", 32'(bus.rom_addr), 32'(0));
    chk("reset.rdata", 32'(bus.rdata), 32'(0));
    chk("reset.rdata_valid", 32'(bus.rdata_valid), 32'(0));
    mon_en = 1'b1;
    reset  = 1'b0;

    // Single requester: grant, 2-cycle read, re-grant no sooner than 2 cycles
    a[0] = 15'h0010;
    step(3'b001, 3'b000, 3'b001, "single.e1", 1'b0);
    step(3'b001, 3'b000, 3'b000, "single.e2", 1'b0);
    step(3'b001, 3'b000, 3'b001, "single.e3", 1'b0);
    step(3'b000, 3'b000, 3'b000, "idle", 1'b0);
    step(3'b000, 3'b000, 3'b000, "idle", 1'b0);

    // All requesting: one grant per cycle, rotation per build
    for (int i = 0; i < 6; i++) step(3'b111, 3'b000, S2_EXP[i], "all3", 1'b1);
    step(3'b000, 3'b000, 3'b000, "idle", 1'b1);
    step(3'b000, 3'b000, 3'b000, "idle", 1'b1);

    // Requesters 1 and 2 alternate
    step(3'b110, 3'b000, 3'b010, "r12.a", 1'b1);
    step(3'b110, 3'b000, 3'b100, "r12.b", 1'b1);
    step(3'b110, 3'b000, 3'b010, "r12.c", 1'b1);
    step(3'b110, 3'b000, 3'b100, "r12.d", 1'b1);
    step(3'b000, 3'b000, 3'b000, "idle", 1'b1);
    step(3'b000, 3'b000, 3'b000, "idle", 1'b1);

    // Requester 2 locks the bus; others starve until the lock drops
    step(3'b100, 3'b100, 3'b100, "lock.win", 1'b1);
    step(3'b111, 3'b100, 3'b000, "lock.gap1", 1'b1);
    step(3'b111, 3'b100, 3'b100, "lock.hold1", 1'b1);
    step(3'b111, 3'b100, 3'b000, "lock.gap2", 1'b1);
    step(3'b111, 3'b100, 3'b100, "lock.hold2", 1'b1);
    step(3'b111, 3'b000, 3'b001, "lock.drop", 1'b1);
    step(3'b111, 3'b000, 3'b010, "lock.after", 1'b1);
    step(3'b000, 3'b000, 3'b000, "idle", 1'b1);
    step(3'b000, 3'b000, 3'b000, "idle", 1'b1);

    // One-cycle pulse from requester 1 (with lock) while 0 wins: ignored
    step(3'b011, 3'b010, 3'b001, "pulse.win0", 1'b1);
    step(3'b001, 3'b000, 3'b000, "pulse.hold", 1'b1);
    step(3'b001, 3'b000, 3'b001, "pulse.regrant", 1'b1);
    step(3'b000, 3'b010, 3'b000, "lock_noreq", 1'b1);
    step(3'b000, 3'b000, 3'b000, "idle", 1'b1);

    // Reset one cycle after a grant: the in-flight read is discarded
    step(3'b010, 3'b000, 3'b010, "prerst", 1'b1);
    reset = 1'b1;
    sbq.delete();
    exp_addr = '0;
    step(3'b111, 3'b000, 3'b000, "rst1", 1'b1);
    chk("rst1.rdata", 32'(bus.rdata), 32'(0));
    chk("rst1.rdata_valid", 32'(bus.rdata_valid), 32'(0));
    step(3'b111, 3'b000, 3'b000, "rst2", 1'b1);
    chk("rst2.rdata_valid", 32'(bus.rdata_valid), 32'(0));
    reset = 1'b0;
    step(3'b111, 3'b000, 3'b001, "postrst.first", 1'b1);
    step(3'b111, 3'b000, 3'b010, "postrst.second", 1'b1);
    step(3'b000, 3'b000, 3'b000, "idle", 1'b1);
    step(3'b000, 3'b000, 3'b000, "idle", 1'b1);
    step(3'b000, 3'b000, 3'b000, "idle", 1'b1);

    chk("sb_drain", 32'(sbq.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
